// File: rtl/regfile_arbiter.sv
// Two-requester register-file arbiter.
// A read requester (two source operands) and a write requester (one result)
// share a single two-port register-file access bus. Grants alternate
// round-robin, except that a write whose destination matches a pending read
// source goes first so the read observes the new value.
module regfile_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic        rd_done,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_req,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_done,
    output logic        rf_rw,
    output logic [2:0]  rf_phase,
    output logic [4:0]  rf_addr1,
    output logic [4:0]  rf_addr2,
    output logic [31:0] rf_wdata1,
    output logic [31:0] rf_wdata2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] WR_ISSUE = 2'd3;

    localparam logic [2:0] PHASE_IDLE  = 3'b000;
    localparam logic [2:0] PHASE_READ  = 3'b001;
    localparam logic [2:0] PHASE_WRITE = 3'b010;

    localparam logic LG_READ  = 1'b0;
    localparam logic LG_WRITE = 1'b1;

    // FSM and latched request fields
    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        last_grant_r;
    logic        last_grant_nxt_s;
    logic [4:0]  rd_addr_a_r;
    logic [4:0]  rd_addr_a_nxt_s;
    logic [4:0]  rd_addr_b_r;
    logic [4:0]  rd_addr_b_nxt_s;
    logic [4:0]  wr_addr_r;
    logic [4:0]  wr_addr_nxt_s;
    logic [31:0] wr_data_r;
    logic [31:0] wr_data_nxt_s;

    // Arbitration decision (meaningful only in IDLE)
    logic        conflict_s;
    logic        grant_rd_s;
    logic        grant_wr_s;

    // Registered outputs and their next values
    logic        rd_done_r;
    logic        rd_done_nxt_s;
    logic        wr_done_r;
    logic        wr_done_nxt_s;
    logic        rf_rw_r;
    logic        rf_rw_nxt_s;
    logic [2:0]  rf_phase_r;
    logic [2:0]  rf_phase_nxt_s;
    logic [4:0]  rf_addr1_r;
    logic [4:0]  rf_addr1_nxt_s;
    logic [4:0]  rf_addr2_r;
    logic [4:0]  rf_addr2_nxt_s;
    logic [31:0] rf_wdata1_r;
    logic [31:0] rf_wdata1_nxt_s;
    logic [31:0] rf_wdata2_r;
    logic [31:0] rf_wdata2_nxt_s;

    // Pick a requester in IDLE: a same-register write wins, otherwise round-robin.
    always_comb begin
        conflict_s = (wr_addr == rd_addr_a) || (wr_addr == rd_addr_b);
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
        if (state_r == IDLE) begin
            if (rd_req && wr_req) begin
                if (conflict_s) begin
                    grant_wr_s = 1'b1;
                end else if (last_grant_r == LG_WRITE) begin
                    grant_rd_s = 1'b1;
                end else begin
                    grant_wr_s = 1'b1;
                end
            end else if (rd_req) begin
                grant_rd_s = 1'b1;
            end else if (wr_req) begin
                grant_wr_s = 1'b1;
            end else begin
                grant_rd_s = 1'b0;
                grant_wr_s = 1'b0;
            end
        end else begin
            grant_rd_s = 1'b0;
            grant_wr_s = 1'b0;
        end
    end

    // Next FSM state, latched request fields and round-robin pointer.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        rd_addr_a_nxt_s  = rd_addr_a_r;
        rd_addr_b_nxt_s  = rd_addr_b_r;
        wr_addr_nxt_s    = wr_addr_r;
        wr_data_nxt_s    = wr_data_r;
        case (state_r)
            IDLE: begin
                if (grant_wr_s) begin
                    state_nxt_s      = WR_ISSUE;
                    wr_addr_nxt_s    = wr_addr;
                    wr_data_nxt_s    = wr_data;
                    last_grant_nxt_s = LG_WRITE;
                end else if (grant_rd_s) begin
                    state_nxt_s      = RD_ISSUE;
                    rd_addr_a_nxt_s  = rd_addr_a;
                    rd_addr_b_nxt_s  = rd_addr_b;
                    last_grant_nxt_s = LG_READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_ISSUE: state_nxt_s = RD_WAIT;
            RD_WAIT:  state_nxt_s = IDLE;
            WR_ISSUE: state_nxt_s = IDLE;
            default:  state_nxt_s = IDLE;
        endcase
    end

    // Decode the register-file bus for the state being entered so outputs come straight from flops.
    always_comb begin
        rd_done_nxt_s   = 1'b0;
        wr_done_nxt_s   = 1'b0;
        rf_rw_nxt_s     = 1'b1;
        rf_phase_nxt_s  = PHASE_IDLE;
        rf_addr1_nxt_s  = 5'd0;
        rf_addr2_nxt_s  = 5'd0;
        rf_wdata1_nxt_s = 32'd0;
        rf_wdata2_nxt_s = 32'd0;
        case (state_nxt_s)
            RD_ISSUE: begin
                rf_phase_nxt_s = PHASE_READ;
                rf_addr1_nxt_s = rd_addr_a_nxt_s;
                rf_addr2_nxt_s = rd_addr_b_nxt_s;
            end
            RD_WAIT: begin
                rd_done_nxt_s = 1'b1;
            end
            WR_ISSUE: begin
                rf_rw_nxt_s     = 1'b0;
                rf_phase_nxt_s  = PHASE_WRITE;
                rf_addr1_nxt_s  = wr_addr_nxt_s;
                rf_addr2_nxt_s  = wr_addr_nxt_s;
                rf_wdata1_nxt_s = wr_data_nxt_s;
                rf_wdata2_nxt_s = wr_data_nxt_s;
                wr_done_nxt_s   = 1'b1;
            end
            IDLE: begin
                rd_done_nxt_s = 1'b0;
            end
            default: begin
                rd_done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched fields and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= LG_WRITE;
            rd_addr_a_r  <= 5'd0;
            rd_addr_b_r  <= 5'd0;
            wr_addr_r    <= 5'd0;
            wr_data_r    <= 32'd0;
            rd_done_r    <= 1'b0;
            wr_done_r    <= 1'b0;
            rf_rw_r      <= 1'b1;
            rf_phase_r   <= PHASE_IDLE;
            rf_addr1_r   <= 5'd0;
            rf_addr2_r   <= 5'd0;
            rf_wdata1_r  <= 32'd0;
            rf_wdata2_r  <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            rd_addr_a_r  <= rd_addr_a_nxt_s;
            rd_addr_b_r  <= rd_addr_b_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            wr_data_r    <= wr_data_nxt_s;
            rd_done_r    <= rd_done_nxt_s;
            wr_done_r    <= wr_done_nxt_s;
            rf_rw_r      <= rf_rw_nxt_s;
            rf_phase_r   <= rf_phase_nxt_s;
            rf_addr1_r   <= rf_addr1_nxt_s;
            rf_addr2_r   <= rf_addr2_nxt_s;
            rf_wdata1_r  <= rf_wdata1_nxt_s;
            rf_wdata2_r  <= rf_wdata2_nxt_s;
        end
    end

    assign rd_done   = rd_done_r;
    assign wr_done   = wr_done_r;
    assign rf_rw     = rf_rw_r;
    assign rf_phase  = rf_phase_r;
    assign rf_addr1  = rf_addr1_r;
    assign rf_addr2  = rf_addr2_r;
    assign rf_wdata1 = rf_wdata1_r;
    assign rf_wdata2 = rf_wdata2_r;

    // The register file returns data during RD_WAIT itself, so the operands
    // are the file's registered outputs gated by the registered done flag.
    assign rd_data_a = rd_done_r ? rf_rdata1 : 32'd0;
    assign rd_data_b = rd_done_r ? rf_rdata2 : 32'd0;

endmodule
